// File: rtl/vram_arbiter.sv
// Frame-buffer arbiter: VGA scan-out (highest priority), hardware clear engine and
// a CPU req/ack port share one synchronous single-port video RAM.
module vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic [9:0]        h_addr,
    input  logic [9:0]        v_addr,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] NPIX     = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_PIX = NPIX - ADDR_W'(1);

    typedef enum logic [1:0] {TAG_NONE, TAG_SCAN, TAG_CPU} tag_e;
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

    clr_state_e        clr_state, clr_state_nx;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
    logic [DATA_W-1:0] clr_color, clr_color_nx;

    tag_e              tag_pipe [2:1];
    logic [2:1]        oob_pipe;
    logic              cpu_rd_busy;

    logic [ADDR_W-1:0] scan_addr;
    logic              cpu_in_range;
    logic              grant_clr, grant_cpu;

    assign clear_busy   = (clr_state == CLR_RUN);
    assign scan_addr    = ADDR_W'(v_addr) * ADDR_W'(H_ACTIVE) + ADDR_W'(h_addr);
    assign cpu_in_range = (cpu_addr < NPIX);
    assign grant_clr    = !valid && clear_busy;
    // clear_start also blocks the CPU so a simultaneous start wins the port
    assign grant_cpu    = !valid && !clear_busy && !clear_start && cpu_req
                          && !cpu_ack && !cpu_rd_busy;

    always_comb begin
        clr_state_nx = clr_state;
        clr_ptr_nx   = clr_ptr;
        clr_color_nx = clr_color;
        case (clr_state)
            CLR_IDLE: if (clear_start) begin
                clr_state_nx = CLR_RUN;
                clr_ptr_nx   = '0;
                clr_color_nx = clear_color;
            end
            CLR_RUN: if (grant_clr) begin
                if (clr_ptr == LAST_PIX) clr_state_nx = CLR_IDLE;
                else                     clr_ptr_nx   = clr_ptr + ADDR_W'(1);
            end
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            clr_state <= CLR_IDLE;
            clr_ptr   <= '0;
            clr_color <= '0;
        end else begin
            clr_state <= clr_state_nx;
            clr_ptr   <= clr_ptr_nx;
            clr_color <= clr_color_nx;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            cpu_rd_busy <= 1'b0;
            tag_pipe[1] <= TAG_NONE;
            tag_pipe[2] <= TAG_NONE;
            oob_pipe    <= '0;
        end else begin
            cpu_ack     <= 1'b0;
            ram_we      <= 1'b0;
            tag_pipe[1] <= TAG_NONE;
            oob_pipe[1] <= 1'b0;

            if (valid) begin
                ram_addr    <= scan_addr;
                tag_pipe[1] <= TAG_SCAN;
            end else if (grant_clr) begin
                ram_addr  <= clr_ptr;
                ram_we    <= 1'b1;
                ram_wdata <= clr_color;
            end else if (grant_cpu) begin
                // out-of-range ops skip the RAM but keep normal ack timing
                if (cpu_in_range) ram_addr <= cpu_addr;
                if (cpu_we) begin
                    cpu_ack <= 1'b1;
                    if (cpu_in_range) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= cpu_wdata;
                    end
                end else begin
                    tag_pipe[1] <= TAG_CPU;
                    oob_pipe[1] <= !cpu_in_range;
                    cpu_rd_busy <= 1'b1;
                end
            end

            tag_pipe[2] <= tag_pipe[1];
            oob_pipe[2] <= oob_pipe[1];

            pix_valid <= (tag_pipe[2] == TAG_SCAN);
            if (tag_pipe[2] == TAG_SCAN) pix_data <= ram_rdata;
            if (tag_pipe[2] == TAG_CPU) begin
                cpu_ack     <= 1'b1;
                cpu_rdata   <= oob_pipe[2] ? '0 : ram_rdata;
                cpu_rd_busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Owns the single-port video frame buffer (640x480, 12-bit RGB444) and shares it between three users. The VGA scan-out path has absolute priority. A CPU/drawing port uses a req/ack handshake. A built-in hardware clear engine fills the whole buffer with one colour. The block sits between the VGA timing controller (valid, h_addr, v_addr) and the synchronous video RAM, and supplies pixel data back to the timing controller's vga_data path.

Parameters:
- H_ACTIVE, 640, active pixels per line; used for address computation.
- V_ACTIVE, 480, active lines.
- ADDR_W, 19, RAM address width; H_ACTIVE*V_ACTIVE = 307200 < 2^19.
- DATA_W, 12, pixel width in {R[11:8], G[7:4], B[3:0]}.

Ports:
- pclk  in  1  pixel clock (25 MHz), the single clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  active-video flag from the VGA timing controller.
- h_addr  in  10  current pixel column; meaningful only when valid=1.
- v_addr  in  10  current pixel row; meaningful only when valid=1.
- pix_data  out  DATA_W  scan-out pixel.
- pix_valid  out  1  pix_data is valid. Equals valid delayed by 2 cycles.
- cpu_req  in  1  CPU request; held high with fields stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  linear pixel address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1 for a read.
- clear_start  in  1  pulse: start a full-buffer clear.
- clear_color  in  DATA_W  fill colour; sampled at clear_start.
- clear_busy  out  1  clear in progress.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after the RAM samples ram_addr.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All outputs go to 0.
  - Pipeline tags are cleared to NONE.
  - Clear engine goes idle; clear pointer = 0.
  - Any outstanding CPU op is dropped with no ack.
- Grant decision at every rising edge E, priority high to low:
  1. SCAN, when valid=1: ram_addr <= v_addr*640 + h_addr, computed as (v<<9)+(v<<7)+h, ram_we <= 0.
  2. CLEAR, when clear_busy=1: ram_addr <= clr_ptr, ram_we <= 1, ram_wdata <= latched colour, clr_ptr <= clr_ptr+1.
  3. CPU, when cpu_req=1, clear_busy=0, cpu_ack=0 and no CPU read is in flight.
  4. Otherwise idle: ram_we <= 0, ram_addr holds.
- Read pipeline: a 2-stage tag pipeline (NONE/SCAN/CPU) follows each grant. A read granted at edge E is captured from ram_rdata at edge E+2.
  - SCAN tag: pix_data <= ram_rdata, pix_valid <= 1.
  - Otherwise pix_valid <= 0 and pix_data holds.
  - Scan latency is exactly 2 cycles. The VGA controller delays hsync/vsync/valid by 2 cycles to match.
- CPU write granted at E:
  - cpu_ack = 1 for the single cycle after E.
  - Address >= 307200: ram_we stays 0 (write dropped) but the op is still acked.
- CPU read granted at E:
  - cpu_ack = 1 and cpu_rdata = ram_rdata for the cycle after E+2.
  - Address >= 307200: no RAM access; cpu_rdata = 0, same ack timing.
- CPU handshake:
  - The requester deasserts cpu_req in the cycle cpu_ack is high.
  - The arbiter never grants the CPU at an edge where cpu_ack=1, so a held request is not re-granted twice.
  - During active video the CPU stalls. Worst-case wait is one active line (640 cycles). It is unbounded while a clear runs.
- Clear FSM, states IDLE/RUN:
  - IDLE -> RUN on clear_start=1: clear_busy <= 1, clr_ptr <= 0, colour latched.
  - RUN -> IDLE at the edge that writes address 307199: clear_busy <= 0 at that same edge.
  - clear_start while busy is ignored; the colour is not re-latched.
  - A clear issued during a pending CPU request does not abort the CPU op. The CPU is simply not granted until clear_busy drops.
- Simultaneous events:
  - valid=1 with clear_busy=1: scan wins and clr_ptr holds.
  - clear_start and cpu_req rising at the same edge: clear starts and the CPU waits.
- Arithmetic: all address arithmetic is ADDR_W wide, with no wrap except clr_ptr, which stops at 307199.

Test Plan:
- valid=1, v_addr=2, h_addr=5 at edge E -> ram_addr=1285, ram_we=0 after E; with ram_rdata=12'hABC, pix_data=12'hABC and pix_valid=1 after E+2.
- valid=0, CPU write addr 100, data 12'h0F0 -> one-cycle ram_we=1, ram_addr=100, ram_wdata=12'h0F0; cpu_ack pulses once the cycle after grant.
- CPU read addr 100 issued while valid=1 for 10 cycles -> no grant until valid=0; then cpu_ack with cpu_rdata=12'h0F0 exactly 2 edges after grant; the scan pix_valid stream is unbroken.
- valid held 0, clear_start with clear_color=12'h123 -> clear_busy high for exactly 307200 cycles; writes to addresses 0..307199 in order, all with data 12'h123.
- Clear running with valid toggling per VGA timing (800x525) -> no write issued while valid=1; busy drops after 307200 write cycles; a CPU request issued mid-clear is acked only after clear_busy=0.
- CPU write addr 307200 -> cpu_ack pulses, ram_we stays 0. reset_n pulled low mid-read -> outputs 0 immediately, no cpu_ack afterward.
